// File: rtl/aes_key_expander.sv
// aes_key_expander
//   Sequential AES-128 key schedule. A start in IDLE loads the cipher key as
//   round key 0; each accepted round key (rk_valid_o & rk_ready_i) advances the
//   schedule by one round until round NROUNDS has been accepted.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       asynchronous reset, active-high
//   start_i     load key_i and begin expansion (honoured only while idle)
//   key_i       cipher key, key_i[127:96] = w0, key_i[127:120] = byte 0
//   rk_o        current round key, same packing as key_i
//   round_o     index of rk_o, 0..NROUNDS
//   rk_valid_o  rk_o / round_o valid
//   rk_ready_i  consumer accepts rk_o when rk_valid_o & rk_ready_i
//   busy_o      high from start acceptance until the last key is accepted
//   done_o      pulse in the cycle round NROUNDS is accepted (combinational on rk_ready_i)

module aes_key_expander #(
   parameter int unsigned WIDTH   = 128,  // only 128 is supported
   parameter int unsigned NROUNDS = 10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] key_i,
   output logic [WIDTH-1:0] rk_o,
   output logic [3:0]       round_o,
   output logic             rk_valid_o,
   input  logic             rk_ready_i,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic [3:0] LastRound = 4'(NROUNDS);

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SboxTable = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [0:0] {StIdle, StEmit} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rk_q, rk_d;
   logic [3:0]       round_q, round_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic [7:0]       rcon_q, rcon_d;

   function automatic logic [7:0] sub_byte(input logic [7:0] x);
      return SboxTable[11'd2047 - {x, 3'b000} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Next round key from the current one.
   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot_w3, sub_w3, temp;
   logic [31:0] n0, n1, n2, n3;
   logic [WIDTH-1:0] rk_next;

   always_comb begin
      w0     = rk_q[127:96];
      w1     = rk_q[95:64];
      w2     = rk_q[63:32];
      w3     = rk_q[31:0];
      rot_w3 = {w3[23:0], w3[31:24]};
      sub_w3 = {sub_byte(rot_w3[31:24]), sub_byte(rot_w3[23:16]),
                sub_byte(rot_w3[15:8]),  sub_byte(rot_w3[7:0])};
      temp   = sub_w3 ^ {rcon_q, 24'h000000};
      n0     = w0 ^ temp;
      n1     = w1 ^ n0;
      n2     = w2 ^ n1;
      n3     = w3 ^ n2;
      rk_next = {n0, n1, n2, n3};
   end

   logic handshake;
   assign handshake = valid_q & rk_ready_i;

   always_comb begin
      state_d = state_q;
      rk_d    = rk_q;
      round_d = round_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      rcon_d  = rcon_q;
      done_o  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               rk_d    = key_i;
               round_d = 4'd0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               rcon_d  = 8'h01;
               state_d = StEmit;
            end
         end
         StEmit: begin
            // start_i is deliberately ignored here, including on the final handshake.
            if (handshake) begin
               if (round_q == LastRound) begin
                  done_o  = 1'b1;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  rk_d    = rk_next;
                  round_d = round_q + 4'd1;
                  rcon_d  = xtime(rcon_q);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         rk_q    <= '0;
         round_q <= 4'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         rcon_q  <= 8'h01;
      end else begin
         state_q <= state_d;
         rk_q    <= rk_d;
         round_q <= round_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         rcon_q  <= rcon_d;
      end
   end

   assign rk_o       = rk_q;
   assign round_o    = round_q;
   assign rk_valid_o = valid_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander
//   Self-checking bench for aes_key_expander. Expected round keys come from a
//   word-oriented key schedule model whose S-box is derived from GF(2^8)
//   inversion plus the affine transform.

module tb_aes_key_expander;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         start_i;
   logic [127:0] key_i;
   logic [127:0] rk_o;
   logic [3:0]   round_o;
   logic         rk_valid_o;
   logic         rk_ready_i;
   logic         busy_o;
   logic         done_o;

   always #5 clk = ~clk;

   aes_key_expander #(
      .WIDTH   (128),
      .NROUNDS (10)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .key_i      (key_i),
      .rk_o       (rk_o),
      .round_o    (round_o),
      .rk_valid_o (rk_valid_o),
      .rk_ready_i (rk_ready_i),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]   sbox_ref [256];
   logic [127:0] exp_keys [11];
   logic [127:0] dut_keys [11];

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d = {b, b};
      return d[15-n -: 8];
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                       ^ 8'h63;
      end
   endtask

   // Standard FIPS-197 word recurrence over w[0..43].
   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
            t = t ^ {rc, 24'h000000};
            rc = gf_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // One expansion. stall_at/stall_len: hold ready low at that round.
   // intrude_at: assert start_i with another key at that round.
   // abort_at: assert rst_i mid-cycle at that round and stop.
   task automatic run_key(input logic [127:0] key, input int stall_at, input int stall_len,
                          input bit rand_ready, input int intrude_at, input int abort_at,
                          output int done_cycle);
      int got = 0;
      int cyc = 0;
      int stalled = 0;
      int dones = 0;
      bit ready;
      done_cycle = -1;
      model_expand(key);
      @(negedge clk);
      start_i = 1'b1;
      key_i   = key;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      key_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
      while (got <= 10 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (got == abort_at) begin
            rst_i = 1'b1;
            #1;
            check_eq("abort rk_o", rk_o, '0);
            check_eq("abort round_o", 128'(round_o), '0);
            check_eq("abort rk_valid_o", 128'(rk_valid_o), '0);
            check_eq("abort busy_o", 128'(busy_o), '0);
            check_eq("abort done_o", 128'(done_o), '0);
            @(posedge clk);
            #1;
            rst_i = 1'b0;
            return;
         end
         check_eq($sformatf("valid r%0d", got), 128'(rk_valid_o), 128'(1));
         check_eq($sformatf("busy r%0d", got), 128'(busy_o), 128'(1));
         check_eq($sformatf("round r%0d", got), 128'(round_o), 128'(got));
         check_eq($sformatf("rk r%0d", got), rk_o, exp_keys[got]);
         dut_keys[got] = rk_o;
         if (got == stall_at && stalled < stall_len) begin
            ready = 1'b0;
            stalled++;
         end else if (rand_ready) begin
            ready = 1'($urandom_range(0, 1));
         end else begin
            ready = 1'b1;
         end
         rk_ready_i = ready;
         if (got == intrude_at) begin
            start_i = 1'b1;
            key_i   = ~key;
         end
         #1;
         check_eq($sformatf("done r%0d", got), 128'(done_o), 128'(ready && got == 10));
         if (done_o) begin
            dones++;
            done_cycle = cyc;
         end
         @(posedge clk);
         if (ready) got++;
         #1;
         start_i = 1'b0;
      end
      check_eq("keys seen", 128'(got), 128'(11));
      check_eq("done count", 128'(dones), 128'(1));
      @(negedge clk);
      rk_ready_i = 1'b0;
      check_eq("idle valid", 128'(rk_valid_o), '0);
      check_eq("idle busy", 128'(busy_o), '0);
      check_eq("idle done", 128'(done_o), '0);
   endtask

   initial begin
      int dc;
      logic [127:0] new_key;
      rst_i      = 1'b1;
      start_i    = 1'b0;
      key_i      = '0;
      rk_ready_i = 1'b0;
      build_sbox();
      #1;
      check_eq("reset rk_o", rk_o, '0);
      check_eq("reset round_o", 128'(round_o), '0);
      check_eq("reset rk_valid_o", 128'(rk_valid_o), '0);
      check_eq("reset busy_o", 128'(busy_o), '0);
      check_eq("reset done_o", 128'(done_o), '0);
      @(negedge clk);
      rst_i = 1'b0;

      // FIPS-197 vector, ready tied high.
      run_key(FipsKey, -1, 0, 1'b0, -1, -1, dc);
      check_eq("fips r1", dut_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
      check_eq("fips r10", dut_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check_eq("fips done latency", 128'(dc), 128'(11));

      // All-zero key.
      run_key('0, -1, 0, 1'b0, -1, -1, dc);
      check_eq("zero r0", dut_keys[0], '0);
      check_eq("zero r1", dut_keys[1], 128'h62636363626363636263636362636363);
      check_eq("zero r10", dut_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // Stall for 3 cycles at round 4.
      run_key(FipsKey, 4, 3, 1'b0, -1, -1, dc);
      check_eq("stall r10", dut_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check_eq("stall done latency", 128'(dc), 128'(14));

      // Start while busy is ignored; a later start loads the new key.
      run_key(FipsKey, -1, 0, 1'b0, 5, -1, dc);
      check_eq("intrude r10", dut_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      new_key = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_key(new_key, -1, 0, 1'b0, -1, -1, dc);
      check_eq("restart r0", dut_keys[0], new_key);

      // Start coinciding with the final handshake is ignored.
      run_key(FipsKey, -1, 0, 1'b0, 10, -1, dc);

      // Reset at round 6, then a clean FIPS run.
      run_key(FipsKey, -1, 0, 1'b0, -1, 6, dc);
      run_key(FipsKey, -1, 0, 1'b0, -1, -1, dc);
      check_eq("post-reset r1", dut_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);

      // Random keys with random back-pressure.
      for (int k = 0; k < 6; k++) begin
         new_key = {$urandom(), $urandom(), $urandom(), $urandom()};
         run_key(new_key, -1, 0, 1'b1, -1, -1, dc);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
